// File: rtl/systolic_result_reader_if.sv
// Handshake bundle between the systolic result reader, the array's parallel
// result bus and the downstream consumer of the serial element stream.
interface systolic_result_reader_if #(
    parameter int SIZE     = 8,
    parameter int O_BITS   = 19,
    parameter int IDX_BITS = $clog2(SIZE)
);
    logic [SIZE*SIZE*O_BITS-1:0] i_c_full;
    logic                        i_start;
    logic                        i_ready;
    logic [O_BITS-1:0]           o_data;
    logic [IDX_BITS-1:0]         o_row;
    logic [IDX_BITS-1:0]         o_col;
    logic                        o_valid;
    logic                        o_last;
    logic                        o_busy;
    logic                        o_overrun;
    logic                        dbg_state;

    // Valid/ready: an element moves on a rising edge where o_valid and
    // i_ready are both high; while o_valid is high and i_ready is low the
    // reader holds o_data/o_row/o_col/o_last unchanged.
    modport slave (
        input  i_c_full, i_start, i_ready,
        output o_data, o_row, o_col, o_valid, o_last, o_busy, o_overrun, dbg_state
    );

    modport master (
        output i_c_full, i_start, i_ready,
        input  o_data, o_row, o_col, o_valid, o_last, o_busy, o_overrun, dbg_state
    );
endinterface

// File: rtl/systolic_result_reader.sv
// Captures a full SIZE x SIZE result matrix on i_start and streams it out
// row-major, one element per valid/ready transfer.
module systolic_result_reader #(
    parameter int SIZE     = 8,
    parameter int I_BITS   = 8,
    parameter int O_BITS   = (I_BITS*2)+$clog2(SIZE),
    parameter int IDX_BITS = $clog2(SIZE)
) (
    input logic                    i_clock,
    input logic                    i_reset,
    systolic_result_reader_if.slave bus
);
    localparam int NUM      = SIZE*SIZE;
    localparam int CNT_BITS = $clog2(NUM);
    localparam logic [CNT_BITS-1:0] LAST_K  = CNT_BITS'(NUM-1);
    localparam logic [IDX_BITS-1:0] LAST_IX = IDX_BITS'(SIZE-1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [O_BITS-1:0]   shadow [NUM];
    logic [CNT_BITS-1:0] k;
    logic [CNT_BITS-1:0] k_inc;
    logic [IDX_BITS-1:0] row, col;
    logic [O_BITS-1:0]   data;
    logic                overrun;
    logic                load, adv, ovr_set;
    logic                xfer, at_last;

    assign k_inc   = k + 1'b1;
    assign xfer    = (state == STREAM) && bus.i_ready;
    assign at_last = (k == LAST_K);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    load      = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                // A start coinciding with the final transfer chains the next
                // frame with no bubble; any other start is dropped and flagged.
                if (xfer && at_last) begin
                    if (bus.i_start) load = 1'b1;
                    else             state_nxt = IDLE;
                end else begin
                    adv     = xfer;
                    ovr_set = bus.i_start;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            k       <= '0;
            row     <= '0;
            col     <= '0;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ovr_set) overrun <= 1'b1;
            if (load) begin
                k    <= '0;
                row  <= '0;
                col  <= '0;
                data <= bus.i_c_full[O_BITS-1:0];
            end else if (adv) begin
                k    <= k_inc;
                data <= shadow[k_inc];
                if (col == LAST_IX) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Frame storage needs no reset; it is only read after a load.
    always_ff @(posedge i_clock) begin
        if (load) begin
            for (int i = 0; i < NUM; i++) shadow[i] <= bus.i_c_full[O_BITS*i +: O_BITS];
        end
    end

    assign bus.o_data    = data;
    assign bus.o_row     = row;
    assign bus.o_col     = col;
    assign bus.o_valid   = (state == STREAM);
    assign bus.o_busy    = (state == STREAM);
    assign bus.o_last    = (state == STREAM) && at_last;
    assign bus.o_overrun = overrun;
    assign bus.dbg_state = (state == STREAM);
endmodule

// File: tb/tb_systolic_result_reader.sv
// Directed bench for systolic_result_reader: drain, backpressure, capture
// isolation, back-to-back frames, overrun and asynchronous reset.
module tb_systolic_result_reader;
    localparam int SIZE   = 8;
    localparam int O_BITS = 19;
    localparam int IDX    = 3;
    localparam int NUM    = SIZE*SIZE;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    systolic_result_reader_if #(.SIZE(SIZE), .O_BITS(O_BITS), .IDX_BITS(IDX)) bus ();

    systolic_result_reader #(.SIZE(SIZE), .I_BITS(8), .O_BITS(O_BITS), .IDX_BITS(IDX)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_frame(input int base);
        for (int i = 0; i < NUM; i++) bus.i_c_full[O_BITS*i +: O_BITS] = O_BITS'(base + i);
    endtask

    task automatic expect_elem(input string tag, input int k, input int base);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_data"},  32'(bus.o_data),  32'(base + k));
        check({tag, "_row"},   32'(bus.o_row),   32'(k / SIZE));
        check({tag, "_col"},   32'(bus.o_col),   32'(k % SIZE));
        check({tag, "_last"},  32'(bus.o_last),  32'(k == NUM-1));
        check({tag, "_busy"},  32'(bus.o_busy),  32'd1);
    endtask

    task automatic expect_idle(input string tag, input logic ovr);
        check({tag, "_valid"},   32'(bus.o_valid),   32'd0);
        check({tag, "_busy"},    32'(bus.o_busy),    32'd0);
        check({tag, "_last"},    32'(bus.o_last),    32'd0);
        check({tag, "_overrun"}, 32'(bus.o_overrun), 32'(ovr));
    endtask

    initial begin
        int exp_k;
        int cyc;
        logic rdy;

        rst_n        = 1'b0;
        bus.i_start  = 1'b0;
        bus.i_ready  = 1'b1;
        bus.i_c_full = '0;

        // Reset values
        step();
        expect_idle("rst", 1'b0);
        check("rst_data", 32'(bus.o_data), 32'd0);
        check("rst_row",  32'(bus.o_row),  32'd0);
        check("rst_col",  32'(bus.o_col),  32'd0);
        rst_n = 1'b1;
        step();
        expect_idle("rst_rel", 1'b0);

        // Basic drain, elements 1..64
        load_frame(1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            expect_elem("drain", k, 1);
            step();
        end
        expect_idle("drain_end", 1'b0);

        // Backpressure 1,0,0,1 with i_c_full overwritten after capture
        load_frame(1);
        bus.i_start = 1'b1;
        step();
        bus.i_start  = 1'b0;
        bus.i_c_full = '1;
        exp_k = 0;
        cyc   = 0;
        while (exp_k < NUM && cyc < 400) begin
            expect_elem("bp", exp_k, 1);
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.i_ready = rdy;
            step();
            if (rdy) exp_k++;
            cyc++;
        end
        check("bp_count", 32'(exp_k), 32'(NUM));
        bus.i_ready = 1'b1;
        expect_idle("bp_end", 1'b0);

        // Back-to-back frames: second start on the last transfer
        load_frame(1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int i = 0; i < 2*NUM; i++) begin
            expect_elem("b2b", i % NUM, (i < NUM) ? 1 : 100);
            if (i == NUM-1) begin
                load_frame(100);
                bus.i_start = 1'b1;
            end
            step();
            bus.i_start = 1'b0;
            if (i == NUM-1) check("b2b_ovr", 32'(bus.o_overrun), 32'd0);
        end
        expect_idle("b2b_end", 1'b0);

        // Overrun: start while element index 10 is presented
        load_frame(1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            expect_elem("ovr", k, 1);
            if (k == 10) begin
                load_frame(200);
                bus.i_start = 1'b1;
            end
            step();
            bus.i_start = 1'b0;
            if (k == 10) check("ovr_set", 32'(bus.o_overrun), 32'd1);
        end
        expect_idle("ovr_end", 1'b1);
        step();
        check("ovr_sticky", 32'(bus.o_overrun), 32'd1);

        // Asynchronous reset mid-stream at element 30
        load_frame(1);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k < 30; k++) step();
        expect_elem("pre_arst", 30, 1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("arst", 1'b0);
        check("arst_data", 32'(bus.o_data), 32'd0);
        check("arst_row",  32'(bus.o_row),  32'd0);
        check("arst_col",  32'(bus.o_col),  32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        expect_idle("arst_rel", 1'b0);
        load_frame(50);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            expect_elem("post_arst", k, 50);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_result_reader.md
Name: systolic_result_reader

Overview:
Output-side counterpart to the systolic array's input feeder. Captures the full parallel result bus of the systolic matrix multiplier (SIZE*SIZE words of O_BITS) on a start pulse and streams it out one element per transfer, row-major, over a valid/ready handshake. Sits between the systolic processor's o_c_full and the downstream consumer (result checker, FIFO or host readout), so results can be drained serially while the array is reloaded.

Parameters:
SIZE, 8, matrix dimension (SIZE >= 2)
I_BITS, 8, operand width of the systolic array (used only to derive O_BITS)
O_BITS, (I_BITS*2)+$clog2(SIZE), width of one result element
IDX_BITS, $clog2(SIZE), width of the row/column index outputs

Ports:
i_clock  in  1  single clock, rising-edge
i_reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_c_full  in  SIZE*SIZE*O_BITS  parallel result bus; element k = bits [O_BITS*k +: O_BITS], k = row*SIZE+col
i_start  in  1  one-cycle pulse: i_c_full holds a complete result matrix this cycle
i_ready  in  1  consumer can accept o_data this cycle
o_data  out  O_BITS  current result element (registered)
o_row  out  IDX_BITS  row index of o_data
o_col  out  IDX_BITS  column index of o_data
o_valid  out  1  o_data/o_row/o_col/o_last valid
o_last  out  1  high with the final element (k = SIZE*SIZE-1)
o_busy  out  1  frame capture held, streaming in progress
o_overrun  out  1  sticky: an i_start was dropped

Behaviour:
- Reset (i_reset=0, async): state IDLE, o_valid=0, o_last=0, o_busy=0, o_overrun=0, o_data=0, o_row=0, o_col=0, element counter=0, shadow register contents don't-care.
- States: IDLE, STREAM.
- IDLE: on rising edge with i_start=1, copy i_c_full into shadow register, counter k=0, go STREAM. Outputs after that edge: o_valid=1, o_busy=1, o_data=element 0, o_row=0, o_col=0. Latency i_start -> first o_valid = 1 cycle.
- STREAM: transfer occurs on edge where o_valid=1 and i_ready=1. On transfer k increments, o_data/o_row/o_col update to element k+1 on the same edge. With i_ready=0, all outputs are held stable (no change of data while valid).
- o_row = k / SIZE, o_col = k % SIZE; col wraps SIZE-1 -> 0 with row+1. Counter width $clog2(SIZE*SIZE).
- o_last = 1 exactly while k = SIZE*SIZE-1 and o_valid=1.
- Transfer of the last element with i_start=0: go IDLE; next cycle o_valid=0, o_busy=0, o_last=0.
- Transfer of the last element with i_start=1 in the same cycle: new frame accepted, shadow reloaded, k=0, stay STREAM; o_valid stays 1 with no bubble, o_data = new element 0.
- i_start=1 in STREAM at any other time: ignored (shadow not overwritten, stream unaffected), o_overrun set to 1; o_overrun clears only on reset.
- i_c_full changes while streaming have no effect; only the shadow copy is emitted.
- Reset asserted mid-stream: frame discarded immediately (async), all outputs to reset values; on release, block waits in IDLE for next i_start.
- No arithmetic on data; elements passed through bit-exact.

Test Plan:
- Basic drain (SIZE=8, O_BITS=19): i_c_full element k = k+1, i_start pulse, i_ready=1 constantly -> o_valid from next cycle for 64 consecutive cycles, o_data = 1..64, (o_row,o_col) = (0,0)..(7,7), o_last only on o_data=64, then o_valid=0, o_busy=0.
- Backpressure: same frame, i_ready toggled 1,0,0,1 pattern -> o_data/o_row/o_col stable during i_ready=0, each value 1..64 delivered exactly once, in order.
- Capture isolation: after i_start, drive i_c_full to all 19'h7FFFF -> stream still outputs 1..64.
- Back-to-back: second i_start (elements k+100) in cycle of last transfer with i_ready=1 -> o_valid never drops; o_data sequence 64 then 100, 101, ...; o_overrun remains 0.
- Overrun: i_start while streaming element 10 -> stream continues with 11..64 from first frame, o_overrun=1 and stays 1 after frame end.
- Async reset mid-stream: assert i_reset=0 between clock edges at element 30 -> o_valid, o_busy, o_overrun, o_data go 0 without a clock edge; after release, new i_start streams element 0 of the new frame.
